wb_master_port: RTL
===================

Name: wb_master_port

Overview:
- Wishbone classic initiator. Turns a simple CPU-side valid/ready request into single Wishbone read/write cycles.
- Drives the master side of the system Wishbone interconnect.
- Adds a bus timeout so an unmapped or dead slave cannot hang the core; a timed-out access is reported as an error response.
- One outstanding transaction at a time; no pipelining or burst.

Parameters:
- WB_DATA_WIDTH, 32, data bus width.
- WB_ADDR_WIDTH, 32, address bus width.
- TIMEOUT_BITS, 8, width of the timeout counter.
- TIMEOUT_CYCLES, 255, number of BUS cycles without ack before abort; legal range 1 to 2^TIMEOUT_BITS-1.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request.
- req_we_i  in  1  1 = write, 0 = read.
- req_adr_i  in  WB_ADDR_WIDTH  byte address.
- req_dat_i  in  WB_DATA_WIDTH  write data.
- req_sel_i  in  4  byte lane enables.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_dat_o  out  WB_DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err_o  out  1  timeout error, qualified by rsp_valid_o.
- wb_dat_o  out  WB_DATA_WIDTH  Wishbone write data.
- wb_we_o  out  1  Wishbone write enable.
- wb_sel_o  out  4  Wishbone byte select.
- wb_adr_o  out  WB_ADDR_WIDTH  Wishbone address.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_dat_i  in  WB_DATA_WIDTH  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.

Behaviour:
- **Reset values:** while rst_i is high, state is IDLE and every registered output is 0 (wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, rsp_valid_o, rsp_dat_o, rsp_err_o, timer). req_ready_o = (state==IDLE), so it reads 1 during reset; it is combinational from state only.
- **State machine:** IDLE, BUS, RESP.
- **IDLE:**
  - Outputs: wb_cyc_o = wb_stb_o = wb_we_o = 0.
  - On an edge with req_valid_i & req_ready_o: register adr, dat, sel and we into the wb_* outputs, set cyc = stb = 1, clear timer, go to BUS.
- **BUS:**
  - Outputs: cyc, stb, adr, dat, sel and we are held stable.
  - Ack: on an edge with wb_ack_i = 1, drop cyc/stb/we, set rsp_valid_o = 1 and rsp_err_o = 0. rsp_dat_o takes wb_dat_i for reads and 0 for writes. Go to RESP.
  - No ack, timer == TIMEOUT_CYCLES-1: drop cyc/stb/we, set rsp_valid_o = 1, rsp_err_o = 1, rsp_dat_o = 0. Go to RESP.
  - Otherwise: timer increments.
  - Ack and timeout on the same edge: ack wins, so rsp_err_o = 0.
- **RESP:** lasts exactly one cycle with rsp_valid_o = 1. Next edge clears rsp_valid_o and rsp_err_o and returns to IDLE. rsp_dat_o holds its value until the next response.
- **Latency:**
  - Request accepted at edge N: cyc high during cycle N+1.
  - Ack present in cycle N+1: rsp_valid_o high in cycle N+2; req_ready_o high again in cycle N+3.
  - Minimum spacing between bus cycles is 2 idle clocks.
- **Write-enable rule:** wb_we_o is never 1 while wb_cyc_o is 0. It always has at least one low cycle between consecutive writes, because the interconnect's write path is edge-triggered on we. Back-to-back writes therefore each produce a fresh we rising edge.
- **Ignored inputs:**
  - wb_ack_i in IDLE or RESP is ignored, with no state change.
  - req_valid_i in BUS or RESP is ignored; the requester must hold it until req_ready_o.
  - Request fields are sampled only on the accept edge; later changes do not affect the cycle in flight.
- **Reset mid-operation:** rst_i asserted during BUS drops cyc/stb/we asynchronously. No response is generated for the aborted transaction.
- **Timer width:** the timer is TIMEOUT_BITS wide and saturates, never wrapping.

Test Plan:
- **Read:** request read adr 0x0010_0004, slave acks 2 cycles after stb with data 0xDEADBEEF -> cyc/stb high 3 cycles, we = 0, sel = 0xF; rsp_valid_o one cycle with rsp_dat_o = 0xDEADBEEF, rsp_err_o = 0.
- **Write:** request write adr 0x0020_0000, dat 0x12345678, sel 0x3, ack in first stb cycle -> wb_dat_o = 0x12345678, wb_sel_o = 0x3, wb_we_o = 1 only while cyc; rsp_dat_o = 0, rsp_valid_o pulses at N+2.
- **Back-to-back writes:** two writes with req_valid_i held high -> wb_we_o falls to 0 for at least 2 clocks between cycles; exactly two we rising edges observed.
- **Timeout:** TIMEOUT_CYCLES = 4, no ack -> cyc high exactly 4 cycles, then rsp_valid_o = 1, rsp_err_o = 1, rsp_dat_o = 0; a late ack after that is ignored.
- **Ack/timeout collision:** TIMEOUT_CYCLES = 4, ack in the 4th BUS cycle -> rsp_err_o = 0, rsp_dat_o = wb_dat_i.
- **Reset mid-cycle:** rst_i pulsed while cyc = 1 -> cyc/stb/we drop before the next clock edge, no rsp_valid_o; req_ready_o = 1 and a new read completes normally afterwards.

Source files
------------

// File: rtl/wb_master_port_if.sv
// CPU-side request/response and Wishbone master signals of wb_master_port.
// Names keep the master-port view (_i into the port, _o out of it).
interface wb_master_port_if #(
   parameter int WB_DATA_WIDTH = 32,
   parameter int WB_ADDR_WIDTH = 32
);
   // Request handshake: a request transfers on a rising edge where req_valid_i
   // and req_ready_o are both 1. The requester holds req_valid_i and the request
   // fields until then. The response is a one-cycle rsp_valid_o strobe with no
   // back-pressure.
   logic                     req_valid_i;
   logic                     req_ready_o;
   logic                     req_we_i;
   logic [WB_ADDR_WIDTH-1:0] req_adr_i;
   logic [WB_DATA_WIDTH-1:0] req_dat_i;
   logic [3:0]               req_sel_i;
   logic                     rsp_valid_o;
   logic [WB_DATA_WIDTH-1:0] rsp_dat_o;
   logic                     rsp_err_o;
   logic [WB_DATA_WIDTH-1:0] wb_dat_o;
   logic                     wb_we_o;
   logic [3:0]               wb_sel_o;
   logic [WB_ADDR_WIDTH-1:0] wb_adr_o;
   logic                     wb_cyc_o;
   logic                     wb_stb_o;
   logic [WB_DATA_WIDTH-1:0] wb_dat_i;
   logic                     wb_ack_i;

   modport master (
      input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
             wb_dat_i, wb_ack_i,
      output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
             wb_dat_o, wb_we_o, wb_sel_o, wb_adr_o, wb_cyc_o, wb_stb_o
   );

   modport slave (
      output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
             wb_dat_i, wb_ack_i,
      input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
             wb_dat_o, wb_we_o, wb_sel_o, wb_adr_o, wb_cyc_o, wb_stb_o
   );
endinterface

// File: rtl/wb_master_port.sv
// Wishbone classic initiator: one single read/write per CPU request, with a
// bus timeout that turns a missing ack into an error response.
module wb_master_port #(
   parameter int WB_DATA_WIDTH  = 32,
   parameter int WB_ADDR_WIDTH  = 32,
   parameter int TIMEOUT_BITS   = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   wb_master_port_if.master  bus,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [TIMEOUT_BITS-1:0] TIMER_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMEOUT_BITS-1:0] TIMER_MAX  = '1;

   state_t                   state_q, state_d;
   logic                     cyc_q, cyc_d;
   logic                     stb_q, stb_d;
   logic                     we_q, we_d;
   logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
   logic [3:0]               sel_q, sel_d;
   logic                     rsp_valid_q, rsp_valid_d;
   logic [WB_DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
   logic                     rsp_err_q, rsp_err_d;
   logic [TIMEOUT_BITS-1:0]  timer_q, timer_d;
   logic                     req_ready;

   assign req_ready = (state_q == IDLE);

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      timer_d     = timer_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid_i && req_ready) begin
               adr_d   = bus.req_adr_i;
               dat_d   = bus.req_dat_i;
               sel_d   = bus.req_sel_i;
               we_d    = bus.req_we_i;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               timer_d = '0;
               state_d = BUS;
            end
         end
         BUS: begin
            // Ack is tested first so an ack on the timeout edge still succeeds.
            if (bus.wb_ack_i) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_dat_d   = we_q ? '0 : bus.wb_dat_i;
               state_d     = RESP;
            end else if (timer_q == TIMER_LAST) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_dat_d   = '0;
               state_d     = RESP;
            end else if (timer_q != TIMER_MAX) begin
               timer_d = timer_q + 1'b1;
            end
         end
         RESP: begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
         timer_q     <= timer_d;
      end
   end

   assign bus.req_ready_o = req_ready;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_dat_o   = rsp_dat_q;
   assign bus.rsp_err_o   = rsp_err_q;
   assign bus.wb_cyc_o    = cyc_q;
   assign bus.wb_stb_o    = stb_q;
   assign bus.wb_we_o     = we_q;
   assign bus.wb_adr_o    = adr_q;
   assign bus.wb_dat_o    = dat_q;
   assign bus.wb_sel_o    = sel_q;
   assign dbg_state_o     = state_q;

endmodule
